dot_product_sched: RTL and testbench

- Sequences a unary product engine, the block that multiplies two WIDTH-bit operands and emits the product as a string of one-cycle `out` pulses followed by `done`, across a vector of LEN operand pairs.
- Accepts pairs over a valid/ready stream, launches the engine once per pair and counts its unary pulses into a binary accumulator.
- Returns the dot product over a valid/ready result interface.
- Sits between the operand buffer and the downstream binary logic.

---
 rtl/dot_product_sched.sv | 118 +++++++++++
 tb/tb_dot_product_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sched.sv
// Dot-product scheduler: feeds operand pairs to a unary product engine one at a
// time, counts its unary pulses into a saturating accumulator and returns the sum.
module dot_product_sched #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 10,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pair_valid,
    output logic             pair_ready,
    input  logic [WIDTH-1:0] pair_w,
    input  logic [WIDTH-1:0] pair_x,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_w,
    output logic [WIDTH-1:0] eng_x,
    input  logic             eng_out,
    input  logic             eng_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy,
    output logic [IDX_W-1:0] pair_idx
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // valid holds data stable until that edge, ready never depends on valid.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] w_q, x_q;
    logic             accept;

    assign accept = pair_valid && (state == FETCH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
            acc   <= '0;
            idx   <= '0;
            w_q   <= '0;
            x_q   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                w_q <= pair_w;
                x_q <= pair_x;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        idx_nxt    = idx;
        pair_ready = 1'b0;
        eng_start  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            FETCH: begin
                pair_ready = 1'b1;
                if (pair_valid) begin
                    // A zero operand would make the engine wrap, so it is skipped.
                    if ((pair_w == '0) || (pair_x == '0)) begin
                        if (idx == LAST_IDX) state_nxt = RESULT;
                        else                 idx_nxt   = idx + 1'b1;
                    end else begin
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (eng_out && (acc != ACC_MAX)) acc_nxt = acc + 1'b1;
                if (eng_done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = RESULT;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    acc_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign res_data = acc;
    assign eng_w    = w_q;
    assign eng_x    = x_q;
    assign pair_idx = idx;
    assign busy     = !((state == FETCH) && (idx == '0));

endmodule

// File: tb/tb_dot_product_sched.sv
// Bench for dot_product_sched: a default instance and an ACC_W=4 instance share
// one behavioural unary engine and identical stimulus.
module tb_dot_product_sched;

    localparam int WIDTH  = 4;
    localparam int LEN    = 4;
    localparam int ACC_W  = 10;
    localparam int IDX_W  = 2;
    localparam int SAT_W  = 4;
    localparam int BUDGET = 2000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pair_valid = 1'b0;
    logic [WIDTH-1:0] pair_w = '0;
    logic [WIDTH-1:0] pair_x = '0;
    logic             res_ready = 1'b0;
    logic             eng_out = 1'b0;
    logic             eng_done = 1'b0;

    logic             pair_ready, eng_start, res_valid, busy;
    logic [WIDTH-1:0] eng_w, eng_x;
    logic [ACC_W-1:0] res_data;
    logic [IDX_W-1:0] pair_idx;

    logic             s_pair_ready, s_eng_start, s_res_valid, s_busy;
    logic [WIDTH-1:0] s_eng_w, s_eng_x;
    logic [SAT_W-1:0] s_res_data;
    logic [IDX_W-1:0] s_pair_idx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int first_cyc = 0;
    int res_cyc = 0;
    bit first_mark = 1'b0;

    // engine model controls
    int eng_rem = 0;
    bit eng_pend = 1'b0;
    bit same_mode = 1'b0;
    bit stray = 1'b0;

    dot_product_sched #(.WIDTH(WIDTH), .LEN(LEN), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_w(pair_w), .pair_x(pair_x),
        .eng_start(eng_start), .eng_w(eng_w), .eng_x(eng_x),
        .eng_out(eng_out), .eng_done(eng_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .pair_idx(pair_idx)
    );

    dot_product_sched #(.WIDTH(WIDTH), .LEN(LEN), .ACC_W(SAT_W), .IDX_W(IDX_W)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .pair_valid(pair_valid), .pair_ready(s_pair_ready), .pair_w(pair_w), .pair_x(pair_x),
        .eng_start(s_eng_start), .eng_w(s_eng_w), .eng_x(s_eng_x),
        .eng_out(eng_out), .eng_done(eng_done),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
        .busy(s_busy), .pair_idx(s_pair_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) if (reset_n && eng_start) start_cnt++;

    // Unary engine: after a start, w*x cycles of out, done either with the last
    // pulse (same_mode) or one cycle later. stray forces out/done regardless.
    always @(negedge clk) begin
        eng_out  = 1'b0;
        eng_done = 1'b0;
        if (!reset_n) begin
            eng_rem  = 0;
            eng_pend = 1'b0;
        end else begin
            if (eng_pend) begin
                eng_done = 1'b1;
                eng_pend = 1'b0;
            end
            if (eng_rem > 0) begin
                eng_out = 1'b1;
                eng_rem--;
                if (eng_rem == 0) begin
                    if (same_mode) eng_done = 1'b1;
                    else           eng_pend = 1'b1;
                end
            end
            if (stray) begin
                eng_out  = 1'b1;
                eng_done = 1'b1;
            end
            if (eng_start) eng_rem = int'(eng_w) * int'(eng_x);
        end
    end

    // ---------------- reference model ----------------
    function automatic int dot_model(input logic [15:0] wv, input logic [15:0] xv);
        int s = 0;
        for (int i = 0; i < LEN; i++) s += int'(wv[i*4 +: 4]) * int'(xv[i*4 +: 4]);
        return s;
    endfunction

    function automatic int launches_model(input logic [15:0] wv, input logic [15:0] xv);
        int n = 0;
        for (int i = 0; i < LEN; i++)
            if (wv[i*4 +: 4] != 4'd0 && xv[i*4 +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic int sat_model(input int v);
        return (v > (1 << SAT_W) - 1) ? (1 << SAT_W) - 1 : v;
    endfunction

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        return 4'($urandom_range(1, 15));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_pair(input logic [3:0] w, input logic [3:0] x);
        int t = 0;
        pair_valid = 1'b1;
        pair_w = w;
        pair_x = x;
        while (!pair_ready && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!pair_ready) begin
            errors++;
            $display("FAIL send_pair_timeout: pair_ready=%0b after %0d cycles, required 1", pair_ready, t);
        end
        if (first_mark) begin
            first_cyc = cyc;
            first_mark = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        pair_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] wv, input logic [15:0] xv);
        first_mark = 1'b1;
        for (int i = 0; i < LEN; i++) send_pair(wv[i*4 +: 4], xv[i*4 +: 4]);
    endtask

    task automatic get_result(output int data, output int sdata, output bit ok);
        int t = 0;
        res_ready = 1'b1;
        while (!res_valid && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        ok = res_valid;
        data = int'(res_data);
        sdata = int'(s_res_data);
        res_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pair_ready !== 1'b1 || eng_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b start=%0b valid=%0b busy=%0b, required 1 0 0 0",
                     pair_ready, eng_start, res_valid, busy);
        end
        checks++;
        if (res_data !== '0 || pair_idx !== '0 || eng_w !== '0 || eng_x !== '0) begin
            errors++;
            $display("FAIL reset_data: res_data=%0d idx=%0d eng_w=%0d eng_x=%0d, required all 0",
                     res_data, pair_idx, eng_w, eng_x);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] wv = {4'd15, 4'd0, 4'd1, 4'd3};
        logic [15:0] xv = {4'd15, 4'd5, 4'd1, 4'd2};
        int s0 = start_cnt;
        int d, sd;
        bit ok;
        res_ready = 1'b1;
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != dot_model(wv, xv)) begin
            errors++;
            $display("FAIL basic_result: valid=%0b data=%0d, required %0d", ok, d, dot_model(wv, xv));
        end
        checks++;
        if (start_cnt - s0 != launches_model(wv, xv)) begin
            errors++;
            $display("FAIL basic_starts: %0d, required %0d", start_cnt - s0, launches_model(wv, xv));
        end
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || pair_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: valid=%0b busy=%0b ready=%0b, required 0 0 1", res_valid, busy, pair_ready);
        end
        checks++;
        if (eng_w !== 4'd15 || eng_x !== 4'd15) begin
            errors++;
            $display("FAIL basic_latch: eng_w=%0d eng_x=%0d, required 15 15", eng_w, eng_x);
        end
    endtask

    task automatic test_all_zero();
        logic [15:0] wv = {4'd0, 4'd0, 4'd4, 4'd0};
        logic [15:0] xv = {4'd0, 4'd0, 4'd0, 4'd7};
        int s0 = start_cnt;
        int d, sd;
        bit ok;
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != 0) begin
            errors++;
            $display("FAIL zero_result: valid=%0b data=%0d, required 0", ok, d);
        end
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL zero_starts: %0d, required 0", start_cnt - s0);
        end
        checks++;
        if (res_cyc - first_cyc != 4) begin
            errors++;
            $display("FAIL zero_latency: %0d cycles, required 4", res_cyc - first_cyc);
        end
    endtask

    task automatic test_hold();
        logic [15:0] wv = {4'd15, 4'd0, 4'd1, 4'd3};
        logic [15:0] xv = {4'd15, 4'd5, 4'd1, 4'd2};
        int t = 0;
        int d, sd, exp;
        bit ok;
        exp = dot_model(wv, xv);
        res_ready = 1'b0;
        send_vec(wv, xv);
        while (!res_valid && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || int'(res_data) != exp || pair_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%0b data=%0d ready=%0b, required 1 %0d 0",
                         i, res_valid, res_data, pair_ready, exp);
            end
            pair_valid = 1'($urandom_range(0, 1));
            pair_w = 4'($urandom_range(0, 15));
            pair_x = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        pair_valid = 1'b0;
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != exp) begin
            errors++;
            $display("FAIL hold_take: valid=%0b data=%0d, required %0d", ok, d, exp);
        end
        wv = {4'd2, 4'd0, 4'd3, 4'd1};
        xv = {4'd2, 4'd9, 4'd3, 4'd1};
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != dot_model(wv, xv)) begin
            errors++;
            $display("FAIL hold_next: data=%0d, required %0d", d, dot_model(wv, xv));
        end
    endtask

    task automatic test_same_cycle_done();
        logic [15:0] wv = {4'd1, 4'd0, 4'd1, 4'd2};
        logic [15:0] xv = {4'd1, 4'd1, 4'd3, 4'd2};
        int d, sd;
        bit ok;
        same_mode = 1'b1;
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != dot_model(wv, xv)) begin
            errors++;
            $display("FAIL same_cycle_done: valid=%0b data=%0d, required %0d", ok, d, dot_model(wv, xv));
        end
        wv = {4'd0, 4'd0, 4'd0, 4'd2};
        xv = {4'd0, 4'd0, 4'd0, 4'd2};
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != 4) begin
            errors++;
            $display("FAIL same_cycle_single: data=%0d, required 4", d);
        end
        same_mode = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int d, sd;
        bit ok;
        send_pair(4'd1, 4'd1);
        send_pair(4'd3, 4'd3);
        repeat (3) @(negedge clk);
        checks++;
        if (pair_ready !== 1'b0 || busy !== 1'b1 || pair_idx !== 2'd1) begin
            errors++;
            $display("FAIL midrun_pre: ready=%0b busy=%0b idx=%0d, required 0 1 1", pair_ready, busy, pair_idx);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pair_ready !== 1'b1 || pair_idx !== '0 || eng_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: ready=%0b idx=%0d start=%0b valid=%0b busy=%0b, required 1 0 0 0 0",
                     pair_ready, pair_idx, eng_start, res_valid, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_vec({4'd1, 4'd1, 4'd1, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1});
        get_result(d, sd, ok);
        checks++;
        if (!ok || d != 4) begin
            errors++;
            $display("FAIL midrun_fresh: data=%0d, required 4", d);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] wv = {4'd1, 4'd1, 4'd15, 4'd15};
        logic [15:0] xv = {4'd1, 4'd1, 4'd15, 4'd15};
        int d, sd;
        bit ok;
        send_vec(wv, xv);
        get_result(d, sd, ok);
        checks++;
        if (!ok || sd != sat_model(dot_model(wv, xv))) begin
            errors++;
            $display("FAIL saturate: sat_data=%0d, required %0d", sd, sat_model(dot_model(wv, xv)));
        end
        checks++;
        if (d != dot_model(wv, xv)) begin
            errors++;
            $display("FAIL saturate_wide: data=%0d, required %0d", d, dot_model(wv, xv));
        end
    endtask

    task automatic test_random();
        logic [15:0] wv, xv;
        int d, sd, s0;
        bit ok;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < LEN; i++) begin
                wv[i*4 +: 4] = rnd_op();
                xv[i*4 +: 4] = rnd_op();
            end
            same_mode = 1'($urandom_range(0, 1));
            s0 = start_cnt;
            send_vec(wv, xv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            get_result(d, sd, ok);
            checks++;
            if (!ok || d != dot_model(wv, xv) || sd != sat_model(dot_model(wv, xv))) begin
                errors++;
                $display("FAIL random_vec%0d: data=%0d sat=%0d, required %0d %0d",
                         v, d, sd, dot_model(wv, xv), sat_model(dot_model(wv, xv)));
            end
            checks++;
            if (start_cnt - s0 != launches_model(wv, xv)) begin
                errors++;
                $display("FAIL random_starts%0d: %0d, required %0d", v, start_cnt - s0, launches_model(wv, xv));
            end
        end
        same_mode = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_all_zero();
        test_hold();
        test_same_cycle_done();
        test_reset_mid_run();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
